// File: rtl/bsg_fifo_pkg.sv
// Shared definitions for the async-reset FIFO family: last-operation
// encoding and the safe clog2 used to size pointers and counters.
package bsg_fifo_pkg;

  typedef enum logic {
    e_last_deq = 1'b0,
    e_last_enq = 1'b1
  } last_op_e;

  // clog2 that never returns 0, so a depth of 1 still gets a 1-bit field
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_tracker_ar.sv
// Read/write pointer pair with last-op flag; derives full/empty when the
// pointers coincide. Asynchronous active-low reset.
module bsg_fifo_tracker_ar
  import bsg_fifo_pkg::*;
#(
  parameter int els_p        = 4,
  parameter int ptr_width_lp = clog2_safe(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enq_i,
  input  logic                    deq_i,
  output logic [ptr_width_lp-1:0] wptr_r_o,
  output logic [ptr_width_lp-1:0] rptr_r_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [ptr_width_lp-1:0] wptr_r;
  logic [ptr_width_lp-1:0] rptr_r;
  last_op_e                last_op_r;
  logic                    ptr_eq;

  // Explicit wrap at els_p-1 so non-power-of-two depths step correctly
  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Pointer advance and last-op capture; the flag only moves on activity
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      last_op_r <= e_last_deq;
    end else begin
      if (enq_i) wptr_r <= ptr_next(wptr_r);
      if (deq_i) rptr_r <= ptr_next(rptr_r);
      if (enq_i)      last_op_r <= e_last_enq;
      else if (deq_i) last_op_r <= e_last_deq;
    end
  end

  assign ptr_eq   = (wptr_r == rptr_r);
  assign full_o   = ptr_eq && (last_op_r == e_last_enq);
  assign empty_o  = ptr_eq && (last_op_r == e_last_deq);
  assign wptr_r_o = wptr_r;
  assign rptr_r_o = rptr_r;

endmodule

// File: rtl/bsg_fifo_1r1w_tracked_ar.sv
// One-read/one-write FIFO: register-array payload store, valid/ready in,
// valid/yumi out, occupancy counter. No bypass: a new entry is visible
// on data_o the cycle after it is written.
module bsg_fifo_1r1w_tracked_ar
  import bsg_fifo_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                v_i,
  input  logic [width_p-1:0]                  data_i,
  output logic                                ready_o,
  output logic                                v_o,
  output logic [width_p-1:0]                  data_o,
  input  logic                                yumi_i,
  output logic [clog2_safe(els_p+1)-1:0]      count_o,
  output logic                                full_o,
  output logic                                empty_o
);

  localparam int ptr_width_lp   = clog2_safe(els_p);
  localparam int count_width_lp = clog2_safe(els_p + 1);

  logic [ptr_width_lp-1:0]   wptr;
  logic [ptr_width_lp-1:0]   rptr;
  logic                      full;
  logic                      empty;
  logic                      enq;
  logic                      deq;
  logic [count_width_lp-1:0] count_r;
  logic [count_width_lp-1:0] ptr_occ;
  logic [width_p-1:0]        mem_r [els_p];

  assign enq = v_i && !full;
  assign deq = yumi_i;

  bsg_fifo_tracker_ar #(
    .els_p        (els_p),
    .ptr_width_lp (ptr_width_lp)
  ) tracker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (enq),
    .deq_i     (deq),
    .wptr_r_o  (wptr),
    .rptr_r_o  (rptr),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Payload write; storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr] <= data_i;
  end

  // Occupancy counter; simultaneous enq/deq leaves it unchanged
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (enq && !deq) begin
      count_r <= count_r + count_width_lp'(1);
    end else if (deq && !enq) begin
      count_r <= count_r - count_width_lp'(1);
    end
  end

  // Occupancy as implied by the pointer pair, used to cross-check count_r
  always_comb begin
    ptr_occ = '0;
    if (full)              ptr_occ = count_width_lp'(els_p);
    else if (wptr >= rptr) ptr_occ = count_width_lp'(wptr - rptr);
    else                   ptr_occ = count_width_lp'(els_p) - count_width_lp'(rptr - wptr);
  end

  assign data_o  = mem_r[rptr];
  assign v_o     = !empty;
  assign ready_o = !full;
  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_r;

  a_no_yumi_when_empty : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o));

  a_count_matches_ptrs : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_r == ptr_occ);

endmodule

// File: tb/tb_bsg_fifo_1r1w_tracked_ar.sv
// Bench for bsg_fifo_1r1w_tracked_ar: three instances (depth 4, 3 and 1)
// driven with directed and random traffic and compared every cycle to a
// circular-buffer reference model.
module tb_bsg_fifo_1r1w_tracked_ar;
  import bsg_fifo_pkg::*;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int ELS0 = 4;
  localparam int ELS1 = 3;
  localparam int ELS2 = 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         v      [N];
  logic         yumi   [N];
  logic [W-1:0] din    [N];
  logic         ready  [N];
  logic         vo     [N];
  logic         full   [N];
  logic         empty  [N];
  logic [W-1:0] dout   [N];
  logic [clog2_safe(ELS0+1)-1:0] cnt0;
  logic [clog2_safe(ELS1+1)-1:0] cnt1;
  logic [clog2_safe(ELS2+1)-1:0] cnt2;
  logic [31:0]  cnt    [N];

  logic [W-1:0] mdata [N][256];
  int           mhead [N];
  int           mcnt  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    cnt[0] = 32'(cnt0);
    cnt[1] = 32'(cnt1);
    cnt[2] = 32'(cnt2);
  end

  bsg_fifo_1r1w_tracked_ar #(.width_p(W), .els_p(ELS0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v[0]), .data_i(din[0]),
    .ready_o(ready[0]), .v_o(vo[0]), .data_o(dout[0]), .yumi_i(yumi[0]),
    .count_o(cnt0), .full_o(full[0]), .empty_o(empty[0]));

  bsg_fifo_1r1w_tracked_ar #(.width_p(W), .els_p(ELS1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v[1]), .data_i(din[1]),
    .ready_o(ready[1]), .v_o(vo[1]), .data_o(dout[1]), .yumi_i(yumi[1]),
    .count_o(cnt1), .full_o(full[1]), .empty_o(empty[1]));

  bsg_fifo_1r1w_tracked_ar #(.width_p(W), .els_p(ELS2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v[2]), .data_i(din[2]),
    .ready_o(ready[2]), .v_o(vo[2]), .data_o(dout[2]), .yumi_i(yumi[2]),
    .count_o(cnt2), .full_o(full[2]), .empty_o(empty[2]));

  function automatic int els_of(input int i);
    case (i)
      0:       return ELS0;
      1:       return ELS1;
      default: return ELS2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mhead[i] = 0;
      mcnt[i]  = 0;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      v[i]    = 1'b0;
      yumi[i] = 1'b0;
      din[i]  = '0;
    end
  endtask

  // Compare every output of every instance against the model
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count[%0d]", i), cnt[i], 32'(mcnt[i]));
      chk($sformatf("v_o[%0d]", i),   32'(vo[i]),    32'(mcnt[i] > 0));
      chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(mcnt[i] < els_of(i)));
      chk($sformatf("full[%0d]", i),  32'(full[i]),  32'(mcnt[i] == els_of(i)));
      chk($sformatf("empty[%0d]", i), 32'(empty[i]), 32'(mcnt[i] == 0));
      if (mcnt[i] > 0)
        chk($sformatf("data[%0d]", i), 32'(dout[i]), 32'(mdata[i][mhead[i]]));
    end
  endtask

  // Called at a negedge with inputs already driven: check, clock, update model
  task automatic step();
    bit enq, deq;
    check_all();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      enq = v[i] && (mcnt[i] < els_of(i));
      deq = yumi[i];
      if (enq) mdata[i][(mhead[i] + mcnt[i]) % 256] = din[i];
      if (deq) mhead[i] = (mhead[i] + 1) % 256;
      mcnt[i] = mcnt[i] + int'(enq) - int'(deq);
    end
    @(negedge clk);
  endtask

  initial begin
    int pv [N];
    int py [N];
    reset_n = 1'b0;
    idle_all();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_empty[%0d]", i), 32'(empty[i]), 32'd1);
      chk($sformatf("rst_ready[%0d]", i), 32'(ready[i]), 32'd1);
      chk($sformatf("rst_vo[%0d]", i),    32'(vo[i]),    32'd0);
      chk($sformatf("rst_full[%0d]", i),  32'(full[i]),  32'd0);
      chk($sformatf("rst_cnt[%0d]", i),   cnt[i],        32'd0);
    end
    reset_n = 1'b1;

    // Fill depth-4 instance with A0..A3, then a fifth offer while full
    for (int k = 0; k < 5; k++) begin
      v[0] = 1'b1;
      din[0] = W'(8'hA0 + k);
      step();
    end
    chk("fill_full", 32'(full[0]), 32'd1);
    chk("fill_ready", 32'(ready[0]), 32'd0);
    v[0] = 1'b0;

    // Drain in order
    for (int k = 0; k < 4; k++) begin
      chk("drain_data", 32'(dout[0]), 32'(8'hA0 + k));
      yumi[0] = 1'b1;
      step();
    end
    yumi[0] = 1'b0;
    chk("drain_empty", 32'(empty[0]), 32'd1);
    step();

    // Reach count 2, then ten cycles of simultaneous enq/deq
    v[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din[0] = W'($urandom);
      step();
    end
    yumi[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din[0] = W'($urandom);
      step();
      chk("simul_cnt", cnt[0], 32'd2);
    end
    yumi[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[0] = W'($urandom);
      step();
    end
    chk("refill_full", 32'(full[0]), 32'd1);
    // Offer and consume while full: no enq this cycle
    yumi[0] = 1'b1;
    din[0] = 8'hEE;
    step();
    chk("full_deq_ready", 32'(ready[0]), 32'd1);
    chk("full_deq_cnt", cnt[0], 32'd3);
    v[0] = 1'b0;
    step();
    yumi[0] = 1'b0;
    step();

    // Asynchronous reset in the middle of a cycle with two entries stored
    chk("pre_rst_cnt", cnt[0], 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt[0], 32'd0);
    chk("async_rst_empty", 32'(empty[0]), 32'd1);
    chk("async_rst_vo", 32'(vo[0]), 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    v[0] = 1'b1;
    din[0] = 8'h11;
    step();
    v[0] = 1'b0;
    chk("post_rst_enq", cnt[0], 32'd1);
    yumi[0] = 1'b1;
    step();
    yumi[0] = 1'b0;

    // Depth-3 wrap: seven values with interleaved dequeues
    for (int k = 0; k < 7; k++) begin
      v[1] = 1'b1;
      din[1] = W'(8'h30 + k);
      yumi[1] = (mcnt[1] > 0) && (k % 2 == 1);
      step();
    end
    v[1] = 1'b0;
    while (mcnt[1] > 0) begin
      yumi[1] = 1'b1;
      step();
    end
    yumi[1] = 1'b0;

    // Depth-1: alternate enq 0x55 / deq
    for (int k = 0; k < 8; k++) begin
      v[2] = (k % 2 == 0);
      din[2] = 8'h55;
      yumi[2] = (k % 2 == 1);
      step();
      chk("els1_full", 32'(full[2]), 32'(k % 2 == 0));
    end
    idle_all();
    step();

    // Random traffic with per-phase biases
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        for (int i = 0; i < N; i++) begin
          pv[i] = int'($urandom_range(10, 95));
          py[i] = int'($urandom_range(10, 95));
        end
      end
      for (int i = 0; i < N; i++) begin
        v[i]    = (int'($urandom_range(0, 99)) < pv[i]);
        din[i]  = W'($urandom);
        yumi[i] = (mcnt[i] > 0) && (int'($urandom_range(0, 99)) < py[i]);
      end
      step();
    end
    idle_all();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
